// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch: instruction-fetch stage of the pipelined MIPS core.
// It owns the PC, drives instr_pc into MEMORY's combinational instruction port,
// and captures the returned word into the IF/ID register. It also handles the
// stall / flush / branch redirect / halt requests from decode and hazard logic.
//
// Optional feature: define FETCH_BOUNDS_CHECK_EN to check the PC against
// [TEXT_LO, TEXT_HI] before each issue. An out-of-range PC halts the stage and
// raises fetch_fault. Without the macro, fetch_fault is a constant 0.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   stall, flush              hold PC + IF/ID / bubble IF/ID
//   branch_taken, branch_target  PC redirect (word aligned)
//   halt_req                  stop fetching until reset
//   instr_pc  (out)           current PC to MEMORY
//   instr_in  (in)            word returned by MEMORY in the same cycle
//   ifid_instr, ifid_pc_plus4, ifid_valid  IF/ID pipeline register
//   halted, fetch_fault       status
//   fetch_count               saturating count of issued instructions
// -----------------------------------------------------------------------------
`ifndef TEXT_SIZE_LO
`define TEXT_SIZE_LO 32'h0040_0000
`endif
`ifndef TEXT_SIZE_HI
`define TEXT_SIZE_HI 32'h0040_FFFC
`endif

module instr_fetch #(
   parameter logic [31:0] TEXT_LO = `TEXT_SIZE_LO,
   parameter logic [31:0] TEXT_HI = `TEXT_SIZE_HI
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt_req,
   output logic [31:0] instr_pc,
   input  logic [31:0] instr_in,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid,
   output logic        halted,
   output logic        fetch_fault,
   output logic [31:0] fetch_count
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] pc4_q;
   logic        valid_q;
   logic [31:0] cnt_q;

   logic [31:0] pc_plus4;
   logic        pc_oob;
   logic        fetch_ok;

   // PC+4 wraps modulo 2^32 by construction.
   assign pc_plus4 = pc_q + 32'd4;
   assign pc_oob   = (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

`ifdef FETCH_BOUNDS_CHECK_EN
   logic fault_q;
   assign fetch_ok    = ~pc_oob;
   assign fetch_fault = fault_q;
`else
   logic unused_oob;
   assign unused_oob  = pc_oob;
   assign fetch_ok    = 1'b1;
   assign fetch_fault = 1'b0;
`endif

   // Low target bits are dropped: the PC is always word aligned.
   logic unused_bt_lsb;
   assign unused_bt_lsb = ^branch_target[1:0];

   assign instr_pc      = pc_q;
   assign ifid_instr    = instr_q;
   assign ifid_pc_plus4 = pc4_q;
   assign ifid_valid    = valid_q;
   assign halted        = (state_q == S_HALT);
   assign fetch_count   = cnt_q;

   // Fetch FSM, PC and IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         pc_q    <= {TEXT_LO[31:2], 2'b00};
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
         fault_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_RUN: begin
               if (halt_req) begin
                  state_q <= S_HALT;
                  instr_q <= '0;
                  pc4_q   <= '0;
                  valid_q <= 1'b0;
               end else if (branch_taken) begin
                  // Wrong-path word is squashed; no delay slot.
                  pc_q    <= {branch_target[31:2], 2'b00};
                  instr_q <= '0;
                  pc4_q   <= '0;
                  valid_q <= 1'b0;
               end else if (stall) begin
                  if (flush) begin
                     instr_q <= '0;
                     pc4_q   <= '0;
                     valid_q <= 1'b0;
                  end
               end else if (!fetch_ok) begin
                  state_q <= S_HALT;
                  instr_q <= '0;
                  pc4_q   <= '0;
                  valid_q <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
                  fault_q <= 1'b1;
`endif
               end else if (flush) begin
                  pc_q    <= pc_plus4;
                  instr_q <= '0;
                  pc4_q   <= '0;
                  valid_q <= 1'b0;
               end else begin
                  pc_q    <= pc_plus4;
                  instr_q <= instr_in;
                  pc4_q   <= pc_plus4;
                  valid_q <= 1'b1;
                  if (cnt_q != 32'hFFFF_FFFF) begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
            end
            default: begin
               // HALT: PC frozen, IF/ID bubbled, exit only through reset.
               instr_q <= '0;
               pc4_q   <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
